// File: rtl/led_pkg.sv
// Shared constants for the LED pattern path: channel count, board clock and pin polarity.
package led_pkg;
    localparam int   NUM_LEDS = 8;
    localparam int   CLK_HZ   = 12_090_000;
    localparam logic LED_ON   = 1'b0;
    localparam logic LED_OFF  = 1'b1;
endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern-in / LED-out bundle between the shift generator, the fade driver and the pins.
interface led_fade_driver_if;
    logic [led_pkg::NUM_LEDS-1:0] pattern_n;
    logic                         enable;
    logic [led_pkg::NUM_LEDS-1:0] LED;
    logic                         fade_tick;

    modport master (output pattern_n, output enable, input LED, input fade_tick);
    modport slave  (input pattern_n, input enable, output LED, output fade_tick);
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with instant attack and linear release, plus the
// registered PWM compare that drives the active-low pin.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 6,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                active,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LEVEL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] level_r;
    logic [PWM_BITS-1:0] level_next_s;
    logic                led_r;
    logic                led_next_s;

    // Level priority: disable clears, attack sets full, release decays with saturation.
    always_comb begin
        level_next_s = level_r;
        if (!enable) begin
            level_next_s = LEVEL_ZERO;
        end else if (active) begin
            level_next_s = LEVEL_MAX;
        end else if (fade_tick) begin
            if (level_r > STEP) begin
                level_next_s = level_r - STEP;
            end else begin
                level_next_s = LEVEL_ZERO;
            end
        end else begin
            level_next_s = level_r;
        end
    end

    // PWM compare; full level bypasses the counter so there is no dropout phase.
    always_comb begin
        led_next_s = LED_OFF;
        if (level_r == LEVEL_MAX) begin
            led_next_s = LED_ON;
        end else if (level_r > pwm_cnt) begin
            led_next_s = LED_ON;
        end else begin
            led_next_s = LED_OFF;
        end
    end

    // Level and output pin registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_r <= LEVEL_ZERO;
            led_r   <= LED_OFF;
        end else begin
            level_r <= level_next_s;
            led_r   <= led_next_s;
        end
    end

    assign led = led_r;
endmodule

// File: rtl/led_fade_driver.sv
// Comet-trail LED driver: synchronizes the async shifter pattern and fans a shared PWM
// counter and fade prescaler out to one fading channel per LED.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS         = 6,
    parameter int FADE_STEP_CYCLES = 47226,
    parameter int FADE_STEP        = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    led_fade_driver_if.slave   bus
);
    localparam int              PS_W     = (FADE_STEP_CYCLES > 2) ? $clog2(FADE_STEP_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_ZERO  = {PS_W{1'b0}};
    localparam logic [PS_W-1:0] PS_ONE   = PS_W'(1);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(FADE_STEP_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_PRE   = PS_W'(FADE_STEP_CYCLES - 2);
    localparam logic [PWM_BITS-1:0] PWM_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic [NUM_LEDS-1:0] sync1_r;
    logic [NUM_LEDS-1:0] sync2_r;
    logic [NUM_LEDS-1:0] active_s;
    logic [NUM_LEDS-1:0] led_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PS_W-1:0]     presc_r;
    logic                fade_tick_r;

    // Input synchronizer, free-running PWM counter and fade prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r     <= {NUM_LEDS{LED_OFF}};
            sync2_r     <= {NUM_LEDS{LED_OFF}};
            pwm_cnt_r   <= PWM_ZERO;
            presc_r     <= PS_ZERO;
            fade_tick_r <= 1'b0;
        end else begin
            sync1_r   <= bus.pattern_n;
            sync2_r   <= sync1_r;
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
            if (presc_r == PS_LAST) begin
                presc_r <= PS_ZERO;
            end else begin
                presc_r <= presc_r + PS_ONE;
            end
            // Registered one cycle early so the pulse coincides with the terminal count.
            fade_tick_r <= (presc_r == PS_PRE);
        end
    end

    assign active_s = ~sync2_r;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (bus.enable),
            .active    (active_s[i]),
            .fade_tick (fade_tick_r),
            .pwm_cnt   (pwm_cnt_r),
            .led       (led_s[i])
        );
    end

    assign bus.LED       = led_s;
    assign bus.fade_tick = fade_tick_r;
endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: hand-derived vector table, corner-case sequences and random
// stimulus checked cycle by cycle against an arithmetic model of the fade behaviour.
module tb_led_fade_driver;
    localparam int PWM_BITS  = 3;
    localparam int FSC       = 4;
    localparam int FADE_STEP = 1;
    localparam int LMAX      = 7;
    localparam int PERIOD    = 8;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] pat;
        int         ncyc;
        logic [7:0] exp_led;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    led_fade_driver_if bus();

    led_fade_driver #(
        .PWM_BITS         (PWM_BITS),
        .FADE_STEP_CYCLES (FSC),
        .FADE_STEP        (FADE_STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-LED brightness as integers, sync stages as pattern history.
    int         m_level [8];
    logic [7:0] m_s1, m_s2, m_led;
    int         m_cyc;

    vec_t vecs [9];
    int   ticks, last_t, cyc;
    bit   seen0, seen1, found;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic en, input logic [7:0] pat);
        bit tick;
        int pwm;
        if (!r) begin
            m_s1 = 8'hFF; m_s2 = 8'hFF; m_led = 8'hFF; m_cyc = 0;
            for (int i = 0; i < 8; i++) m_level[i] = 0;
        end else begin
            tick = (m_cyc % FSC) == FSC - 1;
            pwm  = m_cyc % PERIOD;
            for (int i = 0; i < 8; i++)
                m_led[i] = (m_level[i] == LMAX || m_level[i] > pwm) ? 1'b0 : 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (!en)             m_level[i] = 0;
                else if (!m_s2[i])   m_level[i] = LMAX;
                else if (tick)       m_level[i] = (m_level[i] > FADE_STEP) ? m_level[i] - FADE_STEP : 0;
            end
            m_s2 = m_s1;
            m_s1 = pat;
            m_cyc++;
        end
    endtask

    task automatic step();
        logic exp_tick;
        @(posedge clk);
        model_edge(rst_n, bus.enable, bus.pattern_n);
        #1;
        exp_tick = (rst_n && (m_cyc % FSC) == FSC - 1);
        check("model_led", bus.LED, m_led);
        check("model_tick", {7'd0, bus.fade_tick}, {7'd0, exp_tick});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Release bit 0 from full brightness and wait until the model level reaches target.
    task automatic release_to(input int target, input logic [1:0] phase_mod4, input bit use_phase);
        bus.pattern_n = 8'hFE;
        run(8);
        bus.pattern_n = 8'hFF;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (m_level[0] == target && (!use_phase || (m_cyc % 4) == int'(phase_mod4))) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("release_reached", {7'd0, found}, 8'h01);
    endtask

    initial begin
        bus.pattern_n = 8'h00;
        bus.enable    = 1'b1;
        vecs[0] = '{1'b0, 1'b1, 8'h00, 3, 8'hFF};
        vecs[1] = '{1'b1, 1'b1, 8'h00, 3, 8'hFF};
        vecs[2] = '{1'b1, 1'b1, 8'h00, 1, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 8'h00, 8, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 1, 8'hFF};
        vecs[7] = '{1'b1, 1'b1, 8'h00, 1, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 1, 8'hFF};

        for (int v = 0; v < 9; v++) begin
            rst_n         = vecs[v].rst_n;
            bus.enable    = vecs[v].en;
            bus.pattern_n = vecs[v].pat;
            run(vecs[v].ncyc);
            check($sformatf("vec%0d", v), bus.LED, vecs[v].exp_led);
        end

        // Attack latency from a dark, freshly reset state.
        bus.pattern_n = 8'hFF;
        step();
        rst_n = 1'b1;
        run(4);
        bus.pattern_n = 8'hFE;
        run(3);
        check("attack_e3", bus.LED, 8'hFF);
        step();
        check("attack_e4", bus.LED, 8'hFE);
        for (int k = 0; k < 8; k++) begin
            step();
            check("attack_hold", bus.LED, 8'hFE);
        end

        // Release: seven ticks to dark, tick period exactly FSC.
        bus.pattern_n = 8'hFF;
        run(2);
        ticks = 0; last_t = -1; cyc = 0;
        while (cyc < 60) begin
            if (bus.fade_tick) begin
                if (last_t >= 0) check("tick_period", 8'(cyc - last_t), 8'(FSC));
                last_t = cyc;
                ticks++;
            end
            if (ticks == 7) break;
            step();
            cyc++;
        end
        check("fade_ticks", 8'(ticks), 8'd7);
        run(2);
        for (int k = 0; k < 16; k++) begin
            step();
            check("faded_off", {7'd0, bus.LED[0]}, 8'h01);
        end

        // Shift stream: new LED full on while previous one trails at reduced duty.
        bus.pattern_n = 8'hFE;
        run(40);
        bus.pattern_n = 8'hFD;
        seen0 = 1'b0; seen1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k >= 9 && k <= 16) begin
                check("shift_b1_on", {7'd0, bus.LED[1]}, 8'h00);
                if (bus.LED[0]) seen1 = 1'b1; else seen0 = 1'b1;
            end
        end
        check("shift_b0_pwm", {6'd0, seen0, seen1}, 8'h03);
        bus.pattern_n = 8'hFB;
        run(40);

        // Re-attack coinciding with a fade tick at level 3.
        release_to(3, 2'd1, 1'b1);
        bus.pattern_n = 8'hFE;
        run(2);
        check("simul_tick", {7'd0, bus.fade_tick}, 8'h01);
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            check("simul_full", {7'd0, bus.LED[0]}, 8'h00);
        end

        // enable dropped mid-fade.
        release_to(4, 2'd0, 1'b0);
        bus.enable = 1'b0;
        run(2);
        check("en_off", bus.LED, 8'hFF);
        run(3);
        bus.enable = 1'b1;
        run(10);
        check("en_back_dark", bus.LED, 8'hFF);

        // Reset mid-fade leaves no trail.
        release_to(4, 2'd0, 1'b0);
        rst_n = 1'b0;
        step();
        check("rst_mid", bus.LED, 8'hFF);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("no_trail", bus.LED, 8'hFF);
        end

        // Random stream against the model.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(7, 0) == 0) bus.pattern_n = 8'($urandom);
            bus.enable = ($urandom_range(31, 0) != 0);
            rst_n      = ($urandom_range(199, 0) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
